// File: rtl/matmul_pkg.sv
// matmul_pkg: shared widths and drain FSM state for the matmul result path
package matmul_pkg;
    localparam int DATA_BIT_WIDTH   = 32;
    localparam int DIM_INDEX_WIDTH  = 3;
    localparam int TOTAL_ADDR_WIDTH = DIM_INDEX_WIDTH * 2;
    localparam int TOTAL_MAT_SIZE   = 2 ** TOTAL_ADDR_WIDTH;
    typedef enum logic {S_COLLECT, S_DRAIN} drain_state_t;
endpackage

// File: rtl/matmul_result_ram.sv
// matmul_result_ram: result register file, one sync write port, one combinational read port
module matmul_result_ram import matmul_pkg::*; #(
    parameter int DATA_BIT_WIDTH   = matmul_pkg::DATA_BIT_WIDTH,
    parameter int TOTAL_ADDR_WIDTH = matmul_pkg::TOTAL_ADDR_WIDTH,
    parameter int TOTAL_MAT_SIZE   = 2 ** TOTAL_ADDR_WIDTH
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [TOTAL_ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_BIT_WIDTH-1:0]   wdata,
    input  logic [TOTAL_ADDR_WIDTH-1:0] raddr,
    output logic [DATA_BIT_WIDTH-1:0]   rdata
);
    logic [DATA_BIT_WIDTH-1:0] mem [TOTAL_MAT_SIZE];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/matmul_result_drain.sv
// matmul_result_drain: buffers the engine result stream and drains it row-major over valid/ready.
// MATMUL_DRAIN_BITMAP_EN enables the written-entry bitmap behind missing_err.
module matmul_result_drain import matmul_pkg::*; #(
    parameter int DATA_BIT_WIDTH   = matmul_pkg::DATA_BIT_WIDTH,
    parameter int DIM_INDEX_WIDTH  = matmul_pkg::DIM_INDEX_WIDTH,
    parameter int TOTAL_ADDR_WIDTH = DIM_INDEX_WIDTH * 2,
    parameter int TOTAL_MAT_SIZE   = 2 ** TOTAL_ADDR_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        res_write_en,
    input  logic [TOTAL_ADDR_WIDTH-1:0] res_write_addr,
    input  logic [DATA_BIT_WIDTH-1:0]   res_write_data,
    input  logic                        exec_done,
    input  logic                        err_clr,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_BIT_WIDTH-1:0]   out_data,
    output logic [TOTAL_ADDR_WIDTH-1:0] out_addr,
    output logic                        out_last,
    output logic                        busy,
    output logic                        missing_err,
    output logic                        overrun_err
);
    drain_state_t state;
    logic [TOTAL_ADDR_WIDTH:0] rd_ptr;
    logic [DATA_BIT_WIDTH-1:0] rd_data;
    logic collect, wr_ok, load, accept, final_beat;

    assign collect    = state == S_COLLECT;
    assign wr_ok      = res_write_en && collect;
    // rd_ptr's extra MSB marks that every entry has been loaded
    assign load       = !collect && !rd_ptr[TOTAL_ADDR_WIDTH] && (!out_valid || out_ready);
    assign accept     = out_valid && out_ready;
    assign final_beat = accept && out_last;
    assign busy       = !collect || out_valid;

    matmul_result_ram #(
        .DATA_BIT_WIDTH(DATA_BIT_WIDTH),
        .TOTAL_ADDR_WIDTH(TOTAL_ADDR_WIDTH),
        .TOTAL_MAT_SIZE(TOTAL_MAT_SIZE)
    ) u_ram (
        .clk(clk),
        .we(wr_ok),
        .waddr(res_write_addr),
        .wdata(res_write_data),
        .raddr(rd_ptr[TOTAL_ADDR_WIDTH-1:0]),
        .rdata(rd_data)
    );

    always_ff @(posedge clk)
        if (rst) begin
            state       <= S_COLLECT;
            rd_ptr      <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_addr    <= '0;
            out_last    <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= (overrun_err && !err_clr) || (res_write_en && !collect);
            if (collect && exec_done) begin
                state  <= S_DRAIN;
                rd_ptr <= '0;
            end else if (final_beat)
                state <= S_COLLECT;
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= rd_data;
                out_addr  <= rd_ptr[TOTAL_ADDR_WIDTH-1:0];
                out_last  <= &rd_ptr[TOTAL_ADDR_WIDTH-1:0];
                rd_ptr    <= rd_ptr + 1'b1;
            end else if (accept) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end

`ifdef MATMUL_DRAIN_BITMAP_EN
    logic [TOTAL_MAT_SIZE-1:0] written, written_nxt;
    // include a write landing in the exec_done cycle before judging completeness
    assign written_nxt = written | ({{(TOTAL_MAT_SIZE-1){1'b0}}, wr_ok} << res_write_addr);

    always_ff @(posedge clk)
        if (rst) begin
            written     <= '0;
            missing_err <= 1'b0;
        end else begin
            written     <= final_beat ? '0 : written_nxt;
            missing_err <= (missing_err && !err_clr) || (collect && exec_done && !(&written_nxt));
        end
`else
    assign missing_err = 1'b0;
`endif
endmodule

// File: tb/tb_matmul_result_drain.sv
// tb_matmul_result_drain: randomized fills checked against an array model of the result buffer
module tb_matmul_result_drain;
    import matmul_pkg::*;
    localparam int N  = TOTAL_MAT_SIZE;
    localparam int AW = TOTAL_ADDR_WIDTH;
    localparam int DW = DATA_BIT_WIDTH;
`ifdef MATMUL_DRAIN_BITMAP_EN
    localparam bit BM = 1'b1;
`else
    localparam bit BM = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, res_write_en, exec_done, err_clr, out_ready;
    logic [AW-1:0] res_write_addr;
    logic [DW-1:0] res_write_data;
    logic out_valid, out_last, busy, missing_err, overrun_err;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;

    always #5 clk = ~clk;

    matmul_result_drain dut (
        .clk(clk), .rst(rst),
        .res_write_en(res_write_en), .res_write_addr(res_write_addr), .res_write_data(res_write_data),
        .exec_done(exec_done), .err_clr(err_clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .out_last(out_last), .busy(busy), .missing_err(missing_err), .overrun_err(overrun_err)
    );

    logic [DW-1:0] mem [N];
    bit wr [N];
    bit miss_flag, ovr_exp;
    int total, bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        res_write_en = 1'b0;
        res_write_addr = '0;
        res_write_data = '0;
        exec_done = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic wr_one(input int a, input logic [DW-1:0] d, input bit done);
        res_write_en = 1'b1;
        res_write_addr = AW'(a);
        res_write_data = d;
        exec_done = done;
        mem[a] = d;
        wr[a] = 1'b1;
        @(negedge clk);
    endtask

    // kind 0: addr*3, 1: random, 2: addr+1; skip<0 writes every address
    task automatic fill(input int kind, input int skip);
        int ord[$];
        bit all;
        for (int i = 0; i < N; i++) if (i != skip) ord.push_back(i);
        for (int i = ord.size() - 1; i > 0; i--) begin
            int j, t;
            j = $urandom_range(i, 0);
            t = ord[i]; ord[i] = ord[j]; ord[j] = t;
        end
        for (int k = 0; k < 8; k++) begin
            int a;
            a = $urandom_range(N - 1, 0);
            if (a != skip) wr_one(a, $urandom, 1'b0);
        end
        foreach (ord[k]) begin
            int a;
            logic [DW-1:0] d;
            a = ord[k];
            d = kind == 0 ? DW'(a * 3) : kind == 2 ? DW'(a + 1) : DW'($urandom);
            wr_one(a, d, k == ord.size() - 1);
        end
        idle();
        all = 1'b1;
        for (int i = 0; i < N; i++) if (!wr[i]) all = 1'b0;
        miss_flag = miss_flag | (BM & !all);
        for (int i = 0; i < N; i++) wr[i] = 1'b0;
    endtask

    // mode 0: ready high, 1: ready 1,0,0,1, 2: random ready; inj 1: overrun writes, 2: rst at beat 30
    task automatic drain(input int mode, input int inj);
        int idx, cyc, first;
        bit rdy, pv, pr;
        logic [DW-1:0] pd;
        logic [AW-1:0] pa;
        bit [3:0] pat;
        idx = 0; cyc = 0; first = -1; pv = 0; pr = 0; pd = '0; pa = '0; pat = 4'b1001;
        while (idx < N && cyc < 2000) begin
            cyc++;
            if (cyc == 1) begin
                chk("busy_t1", busy, 1);
                chk("valid_t1", out_valid, 0);
            end
            chk("missing_err", missing_err, miss_flag);
            chk("overrun_err", overrun_err, ovr_exp);
            if (pv && !pr) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, pd);
                chk("hold_addr", out_addr, pa);
            end
            if (out_valid && first < 0) first = cyc;
            rdy = mode == 0 ? 1'b1 : mode == 1 ? pat[(cyc - 1) % 4] : 1'($urandom);
            out_ready = rdy;
            idle();
            if (inj == 1 && (cyc == 3 || cyc == 8)) begin
                res_write_en = 1'b1;
                res_write_addr = AW'(5);
                res_write_data = 32'hDEAD;
                err_clr = cyc == 8;
                ovr_exp = 1'b1;
            end
            if (inj == 1 && cyc == 12) begin
                err_clr = 1'b1;
                ovr_exp = 1'b0;
            end
            if (inj == 2 && idx == 30) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                out_ready = 1'b0;
                miss_flag = 1'b0;
                ovr_exp = 1'b0;
                chk("rst_valid", out_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_missing", missing_err, 0);
                chk("rst_overrun", overrun_err, 0);
                return;
            end
            if (out_valid && rdy) begin
                chk("beat_addr", out_addr, idx);
                chk("beat_data", out_data, mem[idx]);
                chk("beat_last", out_last, idx == N - 1);
                idx++;
            end
            pv = out_valid; pr = rdy; pd = out_data; pa = out_addr;
            @(negedge clk);
        end
        idle();
        chk("drain_beats", idx, N);
        chk("done_busy", busy, 0);
        chk("done_valid", out_valid, 0);
        if (mode == 0) begin
            chk("first_valid_cycle", first, 2);
            chk("last_beat_cycle", cyc, N + 1);
        end
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        miss_flag = 1'b0;
        ovr_exp = 1'b0;
        chk("clr_missing", missing_err, 0);
        chk("clr_overrun", overrun_err, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0; miss_flag = 0; ovr_exp = 0;
        for (int i = 0; i < N; i++) begin mem[i] = '0; wr[i] = 1'b0; end
        idle();
        out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy0", busy, 0);
        chk("rst_missing0", missing_err, 0);
        chk("rst_overrun0", overrun_err, 0);
        rst = 1'b0;
        fill(0, -1); drain(0, 0);
        fill(0, -1); drain(1, 0);
        fill(1, 17); drain(0, 0);
        chk("skip17_missing", missing_err, BM);
        clear_errs();
        fill(1, -1); drain(0, 1);
        fill(1, -1); drain(1, 2);
        fill(2, -1); drain(0, 0);
        fill(1, -1); drain(0, 0);
        fill(1, -1); drain(2, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
